// File: rtl/compound_request_buffer.sv
// Command FIFO feeding the CompoundType consumer: derives y from x, queues up to
// DEPTH entries and presents the head on a sync/notify port with registered outputs.
package compound_types_pkg;
  typedef enum logic {MODE_READ = 1'b0, MODE_WRITE = 1'b1} mode_t;
  typedef struct packed {
    mode_t              mode;
    logic signed [31:0] x;
    logic               y;
  } compound_t;
endpackage

module compound_request_buffer
  import compound_types_pkg::*;
#(
  parameter int                 DEPTH    = 4,
  parameter logic signed [31:0] Y_THRESH = 32'sd0,
  parameter int                 CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  mode_t                      cmd_mode,
  input  logic signed [31:0]         cmd_x,
  input  logic                       cmd_in_sync,
  output logic                       cmd_in_notify,
  output compound_t                  b_out,
  input  logic                       b_out_sync,
  output logic                       b_out_notify,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           wr_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
  localparam logic [LW-1:0]    LVL_ONE   = LW'(1);
  localparam logic [LW-1:0]    LVL_ZERO  = LW'(0);
  localparam logic [LW-1:0]    LVL_LAST  = LW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam compound_t        RESET_ENTRY = '{mode: MODE_READ, x: 32'sd0, y: 1'b0};

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_FULL = 2'd2} state_t;

  function automatic logic y_flag(input logic signed [31:0] x);
    return (x > Y_THRESH);
  endfunction

  compound_t        mem_r [DEPTH];
  compound_t        b_out_r;
  compound_t        entry_s;
  compound_t        head_nxt_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [AW-1:0]    rd_r;
  logic [AW-1:0]    wr_r;
  logic [AW-1:0]    rd_nxt_s;
  logic [LW-1:0]    level_r;
  logic [LW-1:0]    level_nxt_s;
  logic [CNT_W-1:0] wr_count_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             cmd_in_notify_r;
  logic             b_out_notify_r;
  logic             push_s;
  logic             pop_s;

  // Handshakes, next occupancy, next head entry and next control state
  always_comb begin
    push_s      = cmd_in_sync && cmd_in_notify_r;
    pop_s       = b_out_sync && b_out_notify_r;
    entry_s     = '{mode: cmd_mode, x: cmd_x, y: y_flag(cmd_x)};
    level_nxt_s = level_r;
    rd_nxt_s    = rd_r;
    head_nxt_s  = b_out_r;
    cnt_nxt_s   = wr_count_r;
    state_nxt_s = state_r;
    if (push_s && !pop_s) begin
      level_nxt_s = level_r + LVL_ONE;
    end else if (pop_s && !push_s) begin
      level_nxt_s = level_r - LVL_ONE;
    end else begin
      level_nxt_s = level_r;
    end
    if (pop_s) begin
      rd_nxt_s = rd_r + PTR_ONE;
    end else begin
      rd_nxt_s = rd_r;
    end
    // An entry pushed this cycle is not in mem_r yet, so forward it when it becomes the head
    if (level_nxt_s == LVL_ZERO) begin
      head_nxt_s = b_out_r;
    end else if (push_s && (rd_nxt_s == wr_r)) begin
      head_nxt_s = entry_s;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
    if (pop_s && (b_out_r.mode == MODE_WRITE) && (wr_count_r != CNT_MAX)) begin
      cnt_nxt_s = wr_count_r + CNT_ONE;
    end else begin
      cnt_nxt_s = wr_count_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (push_s) state_nxt_s = ST_ACTIVE;
        else        state_nxt_s = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (push_s && !pop_s && (level_r == LVL_LAST))     state_nxt_s = ST_FULL;
        else if (pop_s && !push_s && (level_r == LVL_ONE)) state_nxt_s = ST_IDLE;
        else                                               state_nxt_s = ST_ACTIVE;
      end
      ST_FULL: begin
        if (pop_s) state_nxt_s = ST_ACTIVE;
        else       state_nxt_s = ST_FULL;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Storage, pointers, control state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= RESET_ENTRY;
      state_r         <= ST_IDLE;
      rd_r            <= '0;
      wr_r            <= '0;
      level_r         <= LVL_ZERO;
      b_out_r         <= RESET_ENTRY;
      wr_count_r      <= '0;
      cmd_in_notify_r <= 1'b1;
      b_out_notify_r  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_r] <= entry_s;
        wr_r        <= wr_r + PTR_ONE;
      end
      state_r         <= state_nxt_s;
      rd_r            <= rd_nxt_s;
      level_r         <= level_nxt_s;
      b_out_r         <= head_nxt_s;
      wr_count_r      <= cnt_nxt_s;
      cmd_in_notify_r <= (state_nxt_s != ST_FULL);
      b_out_notify_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  assign cmd_in_notify = cmd_in_notify_r;
  assign b_out_notify  = b_out_notify_r;
  assign b_out         = b_out_r;
  assign level         = level_r;
  assign wr_count      = wr_count_r;
endmodule

// File: tb/tb_compound_request_buffer.sv
// Bench for compound_request_buffer: two instances (default and Y_THRESH=100/CNT_W=2)
// share stimulus and are checked against a queue-based model plus directed vectors.
module tb_compound_request_buffer;
  import compound_types_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  mode_t mode;
  logic signed [31:0] x;
  logic sync, bsync;

  logic cin0, bnot0, cin1, bnot1;
  compound_t bout0, bout1;
  logic [2:0] lvl0, lvl1;
  logic [15:0] wr0;
  logic [1:0] wr1;

  compound_request_buffer #(.DEPTH(4), .Y_THRESH(32'sd0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_mode(mode), .cmd_x(x), .cmd_in_sync(sync),
    .cmd_in_notify(cin0), .b_out(bout0), .b_out_sync(bsync), .b_out_notify(bnot0),
    .level(lvl0), .wr_count(wr0));

  compound_request_buffer #(.DEPTH(4), .Y_THRESH(32'sd100), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_mode(mode), .cmd_x(x), .cmd_in_sync(sync),
    .cmd_in_notify(cin1), .b_out(bout1), .b_out_sync(bsync), .b_out_notify(bnot1),
    .level(lvl1), .wr_count(wr1));

  int checks = 0;
  int failures = 0;

  // Reference model: one queue per instance, last popped entry, saturating counter
  compound_t mq [2][$];
  compound_t hold [2];
  int cnt [2];
  int thr [2];
  int cmax [2];
  compound_t reset_entry;

  typedef struct {
    logic sync; mode_t mode; logic signed [31:0] x; logic bsync;
    logic [2:0] lvl; logic cin; logic bnot; compound_t bout; logic [15:0] wr;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      hold[m] = reset_entry;
      cnt[m] = 0;
    end
  endtask

  task automatic model_update();
    compound_t e;
    for (int m = 0; m < 2; m++) begin
      bit p, q;
      p = sync && (mq[m].size() < 4);
      q = bsync && (mq[m].size() > 0);
      if (q) begin
        e = mq[m].pop_front();
        hold[m] = e;
        if (e.mode == MODE_WRITE && cnt[m] < cmax[m]) cnt[m]++;
      end
      if (p) mq[m].push_back('{mode: mode, x: x, y: (x > thr[m])});
    end
  endtask

  task automatic check_one(input int m, input logic [2:0] lvl, input logic cin, input logic bnot,
                           input compound_t bo, input logic [15:0] wr);
    compound_t exp_out;
    int sz;
    sz = mq[m].size();
    exp_out = (sz > 0) ? mq[m][0] : hold[m];
    chk($sformatf("level[%0d]", m), 64'(lvl), 64'(sz));
    chk($sformatf("cmd_in_notify[%0d]", m), 64'(cin), 64'(sz != 4));
    chk($sformatf("b_out_notify[%0d]", m), 64'(bnot), 64'(sz != 0));
    chk($sformatf("b_out[%0d]", m), 64'(bo), 64'(exp_out));
    chk($sformatf("wr_count[%0d]", m), 64'(wr), 64'(cnt[m]));
  endtask

  task automatic check_model();
    check_one(0, lvl0, cin0, bnot0, bout0, wr0);
    check_one(1, lvl1, cin1, bnot1, bout1, {14'b0, wr1});
  endtask

  task automatic set_in(input logic s, input mode_t md, input logic signed [31:0] xv, input logic bs);
    sync = s; mode = md; x = xv; bsync = bs;
  endtask

  task automatic step();
    if (rst) model_update();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_level"}, 64'(lvl0), 64'(3'd0));
    chk({tag, "_bnot"}, 64'(bnot0), 64'(1'b0));
    chk({tag, "_cin"}, 64'(cin0), 64'(1'b1));
    chk({tag, "_b_out"}, 64'(bout0), 64'(reset_entry));
    chk({tag, "_wr0"}, 64'(wr0), 64'(16'd0));
    chk({tag, "_wr1"}, 64'(wr1), 64'(2'd0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset_entry = '{mode: MODE_READ, x: 32'sd0, y: 1'b0};
    thr[0] = 0; thr[1] = 100;
    cmax[0] = 65535; cmax[1] = 3;
    tbl[0] = '{1'b1, MODE_WRITE, 32'sd5,  1'b0, 3'd1, 1'b1, 1'b1, '{MODE_WRITE, 32'sd5, 1'b1}, 16'd0};
    tbl[1] = '{1'b1, MODE_READ,  -32'sd3, 1'b0, 3'd2, 1'b1, 1'b1, '{MODE_WRITE, 32'sd5, 1'b1}, 16'd0};
    tbl[2] = '{1'b1, MODE_WRITE, 32'sd0,  1'b0, 3'd3, 1'b1, 1'b1, '{MODE_WRITE, 32'sd5, 1'b1}, 16'd0};
    tbl[3] = '{1'b0, MODE_READ,  32'sd0,  1'b1, 3'd2, 1'b1, 1'b1, '{MODE_READ, -32'sd3, 1'b0}, 16'd1};
    tbl[4] = '{1'b0, MODE_READ,  32'sd0,  1'b1, 3'd1, 1'b1, 1'b1, '{MODE_WRITE, 32'sd0, 1'b0}, 16'd1};
    tbl[5] = '{1'b0, MODE_READ,  32'sd0,  1'b1, 3'd0, 1'b1, 1'b0, '{MODE_WRITE, 32'sd0, 1'b0}, 16'd2};
    tbl[6] = '{1'b0, MODE_READ,  32'sd0,  1'b1, 3'd0, 1'b1, 1'b0, '{MODE_WRITE, 32'sd0, 1'b0}, 16'd2};

    rst = 1'b0;
    set_in(1'b0, MODE_READ, 32'sd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("init");
    rst = 1'b1;

    // Order and latency vectors
    for (int i = 0; i < 7; i++) begin
      set_in(tbl[i].sync, tbl[i].mode, tbl[i].x, tbl[i].bsync);
      step();
      chk($sformatf("vec%0d_level", i), 64'(lvl0), 64'(tbl[i].lvl));
      chk($sformatf("vec%0d_cin", i), 64'(cin0), 64'(tbl[i].cin));
      chk($sformatf("vec%0d_bnot", i), 64'(bnot0), 64'(tbl[i].bnot));
      chk($sformatf("vec%0d_b_out", i), 64'(bout0), 64'(tbl[i].bout));
      chk($sformatf("vec%0d_wr", i), 64'(wr0), 64'(tbl[i].wr));
    end

    // Asynchronous reset with two entries queued
    set_in(1'b1, MODE_WRITE, 32'sd9, 1'b0);
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_reset_vals("midrst");
    set_in(1'b0, MODE_READ, 32'sd0, 1'b0);
    step();
    step();
    rst = 1'b1;

    // Full: fifth push is held off until a pop frees a slot
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, MODE_WRITE, 32'(i * 7 + 1), 1'b0);
      step();
    end
    chk("full_cin", 64'(cin0), 64'(1'b0));
    chk("full_level", 64'(lvl0), 64'(3'd4));
    set_in(1'b1, MODE_READ, 32'sd555, 1'b0);
    step();
    chk("full_hold_level", 64'(lvl0), 64'(3'd4));
    bsync = 1'b1;
    step();
    chk("full_pop_level", 64'(lvl0), 64'(3'd3));
    chk("full_pop_cin", 64'(cin0), 64'(1'b1));
    bsync = 1'b0;
    step();
    chk("full_refill_level", 64'(lvl0), 64'(3'd4));
    set_in(1'b0, MODE_READ, 32'sd0, 1'b1);
    repeat (5) step();

    // Streaming at level 2
    set_in(1'b1, MODE_WRITE, 32'sd11, 1'b0);
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, (i % 2 == 0) ? MODE_READ : MODE_WRITE, 32'(i * 13 - 40), 1'b1);
      step();
      chk($sformatf("stream%0d_level", i), 64'(lvl0), 64'(3'd2));
    end
    set_in(1'b0, MODE_READ, 32'sd0, 1'b1);
    repeat (3) step();

    // Threshold on the Y_THRESH=100 instance
    set_in(1'b1, MODE_READ, 32'sd100, 1'b0);
    step();
    chk("thresh_100", 64'(bout1.y), 64'(1'b0));
    set_in(1'b1, MODE_READ, 32'sd101, 1'b1);
    step();
    chk("thresh_101", 64'(bout1.y), 64'(1'b1));
    set_in(1'b1, MODE_READ, -32'sd200, 1'b1);
    step();
    chk("thresh_m200", 64'(bout1.y), 64'(1'b0));
    set_in(1'b0, MODE_READ, 32'sd0, 1'b1);
    step();

    // Saturation of the 2-bit counter
    rst = 1'b0;
    #1;
    model_reset();
    step();
    rst = 1'b1;
    set_in(1'b1, MODE_WRITE, 32'sd1, 1'b1);
    repeat (4) step();
    chk("sat_wr1_at3", 64'(wr1), 64'(2'd3));
    repeat (2) step();
    chk("sat_wr1_hold", 64'(wr1), 64'(2'd3));
    chk("sat_wr0", 64'(wr0), 64'(16'd5));
    set_in(1'b0, MODE_READ, 32'sd0, 1'b1);
    step();

    // Random traffic with occasional asynchronous reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
        check_model();
        step();
        rst = 1'b1;
      end else begin
        set_in($urandom_range(0, 2) != 0,
               ($urandom_range(0, 1) == 1) ? MODE_WRITE : MODE_READ,
               ($urandom_range(0, 3) == 0) ? 32'(int'($urandom_range(98, 102))) : $signed($urandom),
               $urandom_range(0, 2) != 0);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/compound_request_buffer.md
Name: compound_request_buffer

Overview:
- Upstream feeder for the CompoundType consumer stage: accepts raw commands (mode, x), derives the y flag, buffers the results in a small FIFO, and presents them on a sync/notify blocking output port.
- Decouples the command source from the consumer, so up to DEPTH requests can queue while the consumer is busy in another section.
- Uses the CompoundType and Mode types from the shared top-level types package (Mode: read/write, x: signed 32-bit, y: bool).

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- Y_THRESH, 0, signed 32-bit threshold; y = (x > Y_THRESH).
- CNT_W, 16, width of the saturating write-transfer counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous assert, active-low (0 = reset).
- cmd_mode  input  Mode  command mode, read or write.
- cmd_x  input  32 (signed)  command payload.
- cmd_in_sync  input  1  upstream has a valid command this cycle.
- cmd_in_notify  output  1  block can accept a command (FIFO not full).
- b_out  output  CompoundType  head-of-FIFO transaction.
- b_out_sync  input  1  consumer ready to take b_out.
- b_out_notify  output  1  b_out is valid (FIFO not empty).
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- wr_count  output  CNT_W  saturating count of write-mode transactions delivered on b_out.

Behaviour:
- Reset (rst=0, async): FIFO empty, level=0, read/write pointers 0, cmd_in_notify=1, b_out_notify=0, b_out={mode=read, x=0, y=0}, wr_count=0. All state holds reset values while rst=0. Deassertion takes effect at the next rising clk edge.
- Push:
  - Occurs on a rising edge when cmd_in_sync && cmd_in_notify.
  - Writes the entry {cmd_mode, cmd_x, (signed cmd_x > Y_THRESH)} at the write pointer.
  - The comparison is signed 32-bit; x == Y_THRESH gives y=0.
- Pop:
  - Occurs on a rising edge when b_out_sync && b_out_notify.
  - Advances the read pointer. If the popped entry has mode=write, wr_count increments; it saturates at 2^CNT_W-1 and never wraps.
- Pointers wrap modulo DEPTH.
- Level:
  - level += push − pop.
  - Simultaneous push and pop leaves level unchanged and is legal for any 0 < level < DEPTH.
- Notify signals and output data:
  - cmd_in_notify = (level != DEPTH). b_out_notify = (level != 0). Both are derived only from registered state, with no combinational path from sync inputs.
  - b_out always shows the head entry. It holds its value while b_out_notify=0 (last popped value, or the reset value) and is never X.
- Full: cmd_in_notify=0, cmd_in_sync is ignored, and no data is overwritten. Push is allowed again in the cycle after a pop makes level < DEPTH.
- Empty: b_out_notify=0 and b_out_sync is ignored. A push into an empty FIFO makes b_out_notify=1 one cycle after the push edge (latency 1). No bypass path exists.
- Throughput: one push and one pop per cycle sustained.
- Reset mid-operation: all queued entries are discarded immediately, outputs return to reset values, and wr_count clears.
- Internal control state: IDLE (level=0), ACTIVE (0<level<DEPTH), FULL (level=DEPTH).
  - IDLE→ACTIVE on push.
  - ACTIVE→FULL on push without pop when level=DEPTH−1.
  - FULL→ACTIVE on pop.
  - ACTIVE→IDLE on pop without push when level=1.

Test Plan:
- Reset values: drive rst=0 mid-stream with 2 entries queued, then release -> level=0, b_out_notify=0, cmd_in_notify=1, b_out={read,0,0}, wr_count=0.
- Order and latency: push {write,5}, {read,−3}, {write,0} with b_out_sync=0, then b_out_sync=1 -> b_out_notify rises 1 cycle after the first push; outputs appear in order {write,5,y=1}, {read,−3,y=0}, {write,0,y=0}; wr_count=2.
- Full: push 5 commands back-to-back with DEPTH=4 and b_out_sync=0 -> cmd_in_notify=0 after the 4th push; the 5th is not accepted; level=4; after one pop, cmd_in_notify=1 the next cycle and the held 5th command is accepted.
- Streaming: cmd_in_sync=1 and b_out_sync=1 for 10 cycles at level=2 -> level stays 2, one transfer per cycle, pointers wrap with no data corruption.
- Threshold: Y_THRESH=100 with x=100, 101, −200 -> y=0, 1, 0.
- Saturation: CNT_W=2, deliver 5 write-mode entries -> wr_count reaches 3 and holds 3.
